// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead arithmetic paths.
package cla_pkg;

   // Control states of the nibble-serial subtractor.
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Width of one lookahead slice.
   localparam int NIB_W = 4;

   // Two's-complement overflow of res = a + op, where op is the effective
   // addend (b for an add, ~b for a subtract). Shared by the adder and the
   // subtractor so both derive the flag the same way.
   function automatic logic calc_ovf(input logic a_msb,
                                     input logic op_msb,
                                     input logic res_msb);
      return (a_msb == op_msb) && (res_msb != a_msb);
   endfunction

endpackage

// File: rtl/cla_4bit.sv
// Four-bit carry-lookahead adder slice with explicit generate/propagate carries.
module cla_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   // All carries are flattened lookahead terms rather than a ripple chain.
   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
      sum  = p ^ c[3:0];
      cout = c[4];
   end

endmodule

// File: rtl/cla_nibble_serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit lookahead slice per
// cycle, least significant nibble first, with the borrow chained in a register.
module cla_nibble_serial_sub
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = $clog2(NIB);
   localparam int MSB   = WIDTH - 1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_next;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             bout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             last_nib;
   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib_inv;
   logic [NIB_W-1:0] slice_sum;
   logic             slice_cout;

   // Subtraction runs as a + ~b + ~bin, so the slice sees the inverted b nibble.
   cla_4bit u_slice (
      .a    (a_nib),
      .b    (b_nib_inv),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Select the current nibble and merge the slice result into the partial diff.
   always_comb begin
      last_nib  = (cnt_q == CNT_W'(NIB - 1));
      a_nib     = a_q[{cnt_q, 2'b00} +: NIB_W];
      b_nib_inv = ~b_q[{cnt_q, 2'b00} +: NIB_W];
      diff_next = diff_q;
      diff_next[{cnt_q, 2'b00} +: NIB_W] = slice_sum;
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_nib) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand capture, per-nibble accumulation and final flag registration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= ~bin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               diff_q  <= diff_next;
               carry_q <= slice_cout;
               if (last_nib) begin
                  bout_q <= ~slice_cout;
                  ovf_q  <= calc_ovf(a_q[MSB], ~b_q[MSB], diff_next[MSB]);
                  zero_q <= (diff_next == '0);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: doc/cla_nibble_serial_sub.md
Name: cla_nibble_serial_sub

Overview:
- Multi-cycle WIDTH-bit subtractor: diff = a - b - bin.
- Processes one 4-bit slice per cycle through a single 4-bit carry-lookahead slice, least significant nibble first. The borrow chains between cycles in a register.
- Valid/ready handshakes on both sides; one operation in flight at a time.
- Serves as the area-cheap subtract/compare path next to the pipelined CLA adder in the datapath.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived (localparam), number of slice cycles per operation.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Operands valid.
- in_ready  out  1  Block can accept operands. High only in IDLE.
- a  in  WIDTH  Minuend.
- b  in  WIDTH  Subtrahend.
- bin  in  1  Borrow-in.
- out_valid  out  1  Result valid. High only in DONE.
- out_ready  in  1  Consumer accepts the result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  Unsigned borrow-out: 1 when a < b + bin.
- ovf  out  1  Two's-complement overflow of the subtraction.
- zero  out  1  diff == 0.

Behaviour:
- Reset (async assert; deassert synchronised externally):
  - State goes to IDLE.
  - out_valid, diff, bout, ovf, zero are all 0.
  - Internal operand, carry and count registers are 0.
  - in_ready is 1 once reset is released.
- Arithmetic: subtraction is computed as a + ~b + ~bin.
  - Slice carry-in on the first nibble is ~bin.
  - Each later nibble takes the previous slice's carry-out.
  - bout = ~(final carry-out).
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched a and b.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - in_ready = 1.
    - On in_valid && in_ready: latch a, b; carry <= ~bin; cnt <= 0; go to RUN.
  - RUN:
    - in_ready = 0.
    - Each cycle: compute nibble cnt; write it into diff[4*cnt+3:4*cnt] (a right-shift of the operand/result registers is equivalent); carry <= slice cout; cnt++.
    - When cnt == NIB-1: also register bout, ovf and zero, then go to DONE.
  - DONE:
    - out_valid = 1; all result outputs held stable.
    - On out_valid && out_ready: go to IDLE. out_valid drops on the next edge.
- Latency: if operands are accepted at edge T, out_valid is high from edge T+NIB onward. Throughput is one result per NIB+2 cycles minimum (no overlap).
- diff contents during RUN are partial and undefined to consumers. Only out_valid qualifies them.
- in_valid outside IDLE is ignored. Operand inputs need not be held after acceptance.
- out_ready low in DONE (backpressure): block stays in DONE indefinitely; outputs unchanged; in_ready stays 0.
- Simultaneous in_valid with a DONE handshake: not accepted that cycle. Accepted on the next cycle in IDLE.
- Reset mid-RUN or mid-DONE: immediate abort. All outputs are cleared as at reset and the partial result is discarded.
- cnt width is clog2(NIB) and never wraps: it resets to 0 on every accept.

Decomposition:
- Shared package (cla_pkg):
  - State enum {IDLE, RUN, DONE}.
  - Constant NIB_W = 4.
  - A function computing the overflow flag, so the adder and subtractor paths stay identical.
- One sub-module: the codebase's existing cla_4bit, instantiated once.
  - A = current a nibble; B = inverted b nibble; Cin = carry register.
  - All state, counting and flag logic stays in the top level.

Test Plan (WIDTH=16, NIB=4):
1. a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0, zero=0. out_valid rises exactly 4 cycles after the accept edge.
2. a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0, zero=0. This checks the borrow ripple across all 4 nibble cycles.
3. a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1.
4. a=0x5555, b=0x5554, bin=1 → diff=0x0000, zero=1, bout=0, ovf=0.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid; drive a new in_valid meanwhile.
   - Required: out_valid stays 1, diff and flags stay constant, in_ready stays 0, and the new operands are not taken.
   - After out_ready=1 for one cycle, in_ready returns to 1 and the next operation computes correctly.
6. Assert rst_n low after 2 RUN cycles of a=0xFFFF, b=0x0001.
   - Required: out_valid=0, diff=0 and flags=0 immediately; in_ready=1 after release.
   - A following operation a=0x0010, b=0x0001 → diff=0x000F, bout=0.
